// File: rtl/hc595_serializer.sv
// Serialises {seg,sel} MSB-first into a 74HC595 chain and pulses the storage clock.
// Latency: 29*DIV cycles from accept to ready; all outputs registered.
// Backpressure: load is only sampled while ready=1; requests during a frame are dropped.
module hc595_serializer #(
    parameter int DIV = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [5:0] sel,
    input  logic [7:0] seg,
    input  logic       load,
    output logic       ready,
    output logic       shcp,
    output logic       stcp,
    output logic       ds,
    output logic       oe
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam logic [7:0] LAST = 8'(DIV - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [3:0]  bit_idx;
    logic [13:0] frame;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            bit_idx <= 4'd0;
            frame   <= 14'd0;
            shcp    <= 1'b0;
            stcp    <= 1'b0;
            ds      <= 1'b0;
            oe      <= 1'b1;
            ready   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ready && load) begin
                        frame   <= {seg, sel};
                        ds      <= seg[7];
                        state   <= SHIFT;
                        bit_idx <= 4'd0;
                        cnt     <= 8'd0;
                        shcp    <= 1'b0;
                        ready   <= 1'b0;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt == LAST) begin
                        cnt <= 8'd0;
                        if (!shcp) begin
                            shcp <= 1'b1;
                        end else begin
                            shcp <= 1'b0;
                            if (bit_idx == 4'd13) begin
                                stcp  <= 1'b1;
                                state <= LATCH;
                            end else begin
                                // next bit goes out on the falling edge so it is stable at the rise
                                bit_idx <= bit_idx + 4'd1;
                                ds      <= frame[4'd12 - bit_idx];
                            end
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                LATCH: begin
                    if (cnt == LAST) begin
                        cnt   <= 8'd0;
                        stcp  <= 1'b0;
                        oe    <= 1'b0;
                        ready <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hc595_serializer.sv
// Directed bench for hc595_serializer at DIV=2 and DIV=1.
module tb_hc595_serializer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, load_a = 1'b0;
    logic [5:0] sel_a = 6'd0;
    logic [7:0] seg_a = 8'd0;
    logic       ready_a, shcp_a, stcp_a, ds_a, oe_a;

    logic       rst_b = 1'b1, load_b = 1'b0;
    logic [5:0] sel_b = 6'd0;
    logic [7:0] seg_b = 8'd0;
    logic       ready_b, shcp_b, stcp_b, ds_b, oe_b;

    hc595_serializer #(.DIV(2)) dut_a (
        .sys_clk(clk), .sys_rst(rst_a), .sel(sel_a), .seg(seg_a), .load(load_a),
        .ready(ready_a), .shcp(shcp_a), .stcp(stcp_a), .ds(ds_a), .oe(oe_a)
    );

    hc595_serializer #(.DIV(1)) dut_b (
        .sys_clk(clk), .sys_rst(rst_b), .sel(sel_b), .seg(seg_b), .load(load_b),
        .ready(ready_b), .shcp(shcp_b), .stcp(stcp_b), .ds(ds_b), .oe(oe_b)
    );

    int checks = 0;
    int errors = 0;

    // Observers: collect ds at each shcp rise, count stcp activity and protocol violations.
    logic [13:0] sh_a = 14'd0, sh_b = 14'd0;
    int rises_a = 0, pul_a = 0, stc_a = 0, viol_a = 0, cyc_a = 0, last_a = 0;
    int rises_b = 0, pul_b = 0, stc_b = 0, viol_b = 0, cyc_b = 0, last_b = 0;
    logic p_shcp_a = 1'b0, p_stcp_a = 1'b0, p_ds_a = 1'b0, in_fr_a = 1'b0;
    logic p_shcp_b = 1'b0, p_stcp_b = 1'b0, p_ds_b = 1'b0, in_fr_b = 1'b0;

    always @(negedge clk) begin
        p_shcp_a <= shcp_a;
        p_stcp_a <= stcp_a;
        p_ds_a   <= ds_a;
        cyc_a    <= cyc_a + 1;
        if (ready_a || rst_a) in_fr_a <= 1'b0;
        if (shcp_a && !p_shcp_a) begin
            sh_a    <= {sh_a[12:0], ds_a};
            rises_a <= rises_a + 1;
            last_a  <= cyc_a;
            in_fr_a <= 1'b1;
            if ((in_fr_a && (cyc_a - last_a != 4)) || (ds_a != p_ds_a)) viol_a <= viol_a + 1;
        end else if (shcp_a && stcp_a) begin
            viol_a <= viol_a + 1;
        end
        if (stcp_a) stc_a <= stc_a + 1;
        if (stcp_a && !p_stcp_a) pul_a <= pul_a + 1;
    end

    always @(negedge clk) begin
        p_shcp_b <= shcp_b;
        p_stcp_b <= stcp_b;
        p_ds_b   <= ds_b;
        cyc_b    <= cyc_b + 1;
        if (ready_b || rst_b) in_fr_b <= 1'b0;
        if (shcp_b && !p_shcp_b) begin
            sh_b    <= {sh_b[12:0], ds_b};
            rises_b <= rises_b + 1;
            last_b  <= cyc_b;
            in_fr_b <= 1'b1;
            if ((in_fr_b && (cyc_b - last_b != 2)) || (ds_b != p_ds_b)) viol_b <= viol_b + 1;
        end else if (shcp_b && stcp_b) begin
            viol_b <= viol_b + 1;
        end
        if (stcp_b) stc_b <= stc_b + 1;
        if (stcp_b && !p_stcp_b) pul_b <= pul_b + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Counts cycles until ready_a returns; optionally fires a junk load mid-frame.
    task automatic wait_rdy_a(input bit junk, output int n);
        n = 0;
        while (!ready_a && n < 1000) begin
            tick();
            n++;
            if (junk && n == 20) begin
                sel_a  = 6'b111111;
                seg_a  = 8'hFF;
                load_a = 1'b1;
            end else if (junk && n == 21) begin
                load_a = 1'b0;
            end
        end
    endtask

    typedef struct {
        logic [5:0]  sel;
        logic [7:0]  seg;
        logic [13:0] exp;
        bit          junk;
    } vec_t;

    vec_t tbl[4];

    task automatic run_frame_a(input vec_t v);
        int n, r0, p0, s0, v0;
        r0 = rises_a; p0 = pul_a; s0 = stc_a; v0 = viol_a;
        sel_a  = v.sel;
        seg_a  = v.seg;
        load_a = 1'b1;
        tick();
        load_a = 1'b0;
        check("accept_ready", ready_a, 0);
        check("accept_ds", ds_a, v.exp[13]);
        check("accept_shcp", shcp_a, 0);
        wait_rdy_a(v.junk, n);
        check("busy_cycles", n, 58);
        check("frame_bits", sh_a, v.exp);
        check("shcp_rises", rises_a - r0, 14);
        check("stcp_pulses", pul_a - p0, 1);
        check("stcp_width", stc_a - s0, 2);
        check("protocol", viol_a - v0, 0);
        check("oe_after_latch", oe_a, 0);
    endtask

    initial begin
        int n, r0, p0, s0, v0;
        tbl[0] = '{6'b000001, 8'hC0, 14'h3001, 1'b1};
        tbl[1] = '{6'b000010, 8'h90, 14'h2402, 1'b0};
        tbl[2] = '{6'b111111, 8'h00, 14'h003F, 1'b1};
        tbl[3] = '{6'b000000, 8'hFF, 14'h3FC0, 1'b0};

        for (int i = 0; i < 10; i++) tick();
        check("rst_shcp", shcp_a, 0);
        check("rst_stcp", stcp_a, 0);
        check("rst_ds", ds_a, 0);
        check("rst_oe", oe_a, 1);
        check("rst_ready", ready_a, 0);
        check("rst_ready_b", ready_b, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();
        check("ready_after_rst", ready_a, 1);
        check("oe_before_latch", oe_a, 1);

        for (int i = 0; i < 4; i++) run_frame_a(tbl[i]);

        // Back-to-back with load held high across both frames.
        r0 = rises_a; p0 = pul_a;
        sel_a = 6'b000001; seg_a = 8'hC0; load_a = 1'b1;
        tick();
        sel_a = 6'b000010; seg_a = 8'h90;
        wait_rdy_a(1'b0, n);
        check("b2b_busy1", n, 58);
        check("b2b_frame1", sh_a, 14'h3001);
        tick();
        load_a = 1'b0;
        check("b2b_accept2", ready_a, 0);
        check("b2b_gap0", shcp_a, 0);
        tick();
        check("b2b_gap1", shcp_a, 0);
        tick();
        check("b2b_rise", shcp_a, 1);
        wait_rdy_a(1'b0, n);
        check("b2b_busy2", n, 56);
        check("b2b_frame2", sh_a, 14'h2402);
        check("b2b_rises", rises_a - r0, 28);
        check("b2b_pulses", pul_a - p0, 2);

        // Reset in the middle of a frame.
        r0 = rises_a; p0 = pul_a;
        sel_a = 6'b000001; seg_a = 8'hC0; load_a = 1'b1;
        tick();
        load_a = 1'b0;
        n = 0;
        while (rises_a - r0 < 5 && n < 200) begin
            tick();
            n++;
        end
        check("mid_rises", rises_a - r0, 5);
        rst_a = 1'b1;
        tick();
        check("mid_shcp", shcp_a, 0);
        check("mid_stcp", stcp_a, 0);
        check("mid_ds", ds_a, 0);
        check("mid_oe", oe_a, 1);
        check("mid_ready", ready_a, 0);
        tick(); tick();
        check("mid_no_pulse", pul_a - p0, 0);
        rst_a = 1'b0;
        tick();
        check("mid_ready_back", ready_a, 1);
        run_frame_a(tbl[1]);

        // DIV=1 instance.
        r0 = rises_b; p0 = pul_b; s0 = stc_b; v0 = viol_b;
        sel_b = 6'b000010; seg_b = 8'h90; load_b = 1'b1;
        tick();
        load_b = 1'b0;
        check("d1_accept", ready_b, 0);
        check("d1_ds0", ds_b, 1);
        n = 0;
        while (!ready_b && n < 1000) begin
            tick();
            n++;
        end
        check("d1_busy", n, 29);
        check("d1_frame", sh_b, 14'h2402);
        check("d1_rises", rises_b - r0, 14);
        check("d1_pulses", pul_b - p0, 1);
        check("d1_stcp_width", stc_b - s0, 1);
        check("d1_protocol", viol_b - v0, 0);
        check("d1_oe", oe_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
